// File: rtl/seq_restoring_divider_pkg.sv
// Shared definitions for the multiply/divide arithmetic slice.
package muldiv_pkg;

  // Divider control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // Width of a counter that must hold the values 0..2*w.
  function automatic int cnt_width(input int w);
    return $clog2(2 * w + 1);
  endfunction

endpackage

// File: rtl/seq_restoring_divider_if.sv
// Request/response bundle of the sequential divider.
// Handshake rule (both sides): a transfer happens on a rising clk edge where
// valid && ready are both high; the producer keeps valid and its payload
// stable until that edge, and ready never depends combinationally on valid.
interface seq_restoring_divider_if #(
  parameter int W = 3
);
  logic           in_valid;
  logic           in_ready;
  logic [2*W-1:0] dividend;
  logic [W-1:0]   divisor;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] quotient;
  logic [W-1:0]   remainder;
  logic           div_by_zero;

  // Requester / result consumer side.
  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );

  // Divider side.
  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_restoring_divider_div_step.sv
// One combinational restoring-division stage.
module div_step #(
  parameter int W = 3
) (
  input  logic [W:0]   partial_i,
  input  logic         bit_i,
  input  logic [W-1:0] divisor_i,
  output logic [W:0]   partial_o,
  output logic         q_o
);
  logic [W+1:0] trial;
  logic [W+1:0] diff;

  // Shift in the next dividend bit and subtract; the borrow-out is the sign.
  // Since partial < divisor, the restored/new partial always fits in W+1 bits.
  always_comb begin
    trial     = {partial_i, bit_i};
    diff      = trial - {2'b00, divisor_i};
    q_o       = ~diff[W+1];
    partial_o = q_o ? diff[W:0] : trial[W:0];
  end
endmodule

// File: rtl/seq_restoring_divider.sv
// Radix-2 restoring divider: 2W-bit dividend / W-bit divisor, one quotient
// bit per clock, result registered and held until the consumer takes it.
module seq_restoring_divider
  import muldiv_pkg::*;
#(
  parameter int W = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  seq_restoring_divider_if.slave   bus,
  output state_e                   state_o
);
  localparam int CW = cnt_width(W);
  localparam logic [CW-1:0] CNT_LOAD = CW'(2 * W);

  state_e         state_q;
  logic           in_ready_q;
  logic           out_valid_q;
  logic [2*W-1:0] dividend_q;
  logic [W-1:0]   divisor_q;
  logic [W:0]     partial_q;
  logic [CW-1:0]  cnt_q;
  logic [2*W-1:0] quotient_q;
  logic [W-1:0]   remainder_q;
  logic           dbz_q;

  logic [W:0]     partial_d;
  logic           qbit_d;

  div_step #(.W(W)) u_step (
    .partial_i (partial_q),
    .bit_i     (dividend_q[2*W-1]),
    .divisor_i (divisor_q),
    .partial_o (partial_d),
    .q_o       (qbit_d)
  );

  // Control FSM plus datapath registers. DONE spends its first cycle loading
  // the result registers, then raises out_valid and waits for out_ready.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      dividend_q  <= '0;
      divisor_q   <= '0;
      partial_q   <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            dividend_q <= bus.dividend;
            divisor_q  <= bus.divisor;
            partial_q  <= '0;
            cnt_q      <= CNT_LOAD;
            in_ready_q <= 1'b0;
            state_q    <= (bus.divisor == '0) ? DONE : BUSY;
          end
        end
        BUSY: begin
          dividend_q <= {dividend_q[2*W-2:0], qbit_d};
          partial_q  <= partial_d;
          cnt_q      <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
            if (divisor_q == '0) begin
              quotient_q  <= '1;
              remainder_q <= '0;
              dbz_q       <= 1'b1;
            end else begin
              quotient_q  <= dividend_q;
              remainder_q <= partial_q[W-1:0];
              dbz_q       <= 1'b0;
            end
          end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.div_by_zero = dbz_q;
  assign state_o         = state_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed bench for seq_restoring_divider at W = 3.
module tb_seq_restoring_divider;
  import muldiv_pkg::*;

  localparam int W  = 3;
  localparam int RW = 3 * W + 1;

  logic   clk;
  logic   rst_n;
  state_e state_o;

  seq_restoring_divider_if #(.W(W)) bus ();

  seq_restoring_divider #(.W(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .state_o (state_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [RW-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [2*W-1:0] q, input logic [W-1:0] r, input logic dbz);
    exp_q.push_back({q, r, dbz});
  endtask

  // ---------------- driver ----------------
  // Issue one request, wait for the result, compare it with the head of the
  // expected queue, then complete the output handshake. lat counts edges from
  // the accept edge to the first cycle out_valid is seen high.
  task automatic run_op(input logic [2*W-1:0] dd, input logic [W-1:0] dv, input string tag,
                        output int lat);
    int n;
    logic [RW-1:0] e;
    bus.dividend  = dd;
    bus.divisor   = dv;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    if (exp_q.size() == 0) begin
      n_cmp++; n_err++;
      $display("FAIL %s: scoreboard empty, got nothing expected", tag);
    end else begin
      e = exp_q.pop_front();
      check({tag, " out_valid"}, bus.out_valid, 1);
      check({tag, " quotient"}, bus.quotient, e[RW-1 -: 2*W]);
      check({tag, " remainder"}, bus.remainder, e[W:1]);
      check({tag, " div_by_zero"}, bus.div_by_zero, e[0]);
    end
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [2*W-1:0] dd;
    logic [W-1:0]   dv;
    logic [2*W-1:0] q;
    logic [W-1:0]   r;
    logic           dbz;
    int             lat;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int lat;
    logic [2*W-1:0] q_hold;
    logic [W-1:0]   r_hold;

    vecs[0] = '{dd: 6'd42, dv: 3'd6, q: 6'd7,  r: 3'd0, dbz: 1'b0, lat: 7};
    vecs[1] = '{dd: 6'd63, dv: 3'd4, q: 6'd15, r: 3'd3, dbz: 1'b0, lat: 7};
    vecs[2] = '{dd: 6'd5,  dv: 3'd7, q: 6'd0,  r: 3'd5, dbz: 1'b0, lat: 7};
    vecs[3] = '{dd: 6'd5,  dv: 3'd0, q: 6'd63, r: 3'd0, dbz: 1'b1, lat: 1};
    vecs[4] = '{dd: 6'd63, dv: 3'd1, q: 6'd63, r: 3'd0, dbz: 1'b0, lat: 7};
    vecs[5] = '{dd: 6'd62, dv: 3'd7, q: 6'd8,  r: 3'd6, dbz: 1'b0, lat: 7};
    vecs[6] = '{dd: 6'd0,  dv: 3'd3, q: 6'd0,  r: 3'd0, dbz: 1'b0, lat: 7};
    vecs[7] = '{dd: 6'd0,  dv: 3'd0, q: 6'd63, r: 3'd0, dbz: 1'b1, lat: 1};
    vecs[8] = '{dd: 6'd37, dv: 3'd5, q: 6'd7,  r: 3'd2, dbz: 1'b0, lat: 7};

    bus.in_valid  = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    bus.out_ready = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Reset state
    check("rst in_ready", bus.in_ready, 1);
    check("rst out_valid", bus.out_valid, 0);
    check("rst quotient", bus.quotient, 0);
    check("rst remainder", bus.remainder, 0);
    check("rst div_by_zero", bus.div_by_zero, 0);
    check("rst state", state_o, IDLE);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Table vectors
    for (int i = 0; i < 9; i++) begin
      push_exp(vecs[i].q, vecs[i].r, vecs[i].dbz);
      run_op(vecs[i].dd, vecs[i].dv, $sformatf("vec%0d", i), lat);
      check($sformatf("vec%0d latency", i), lat, vecs[i].lat);
      check($sformatf("vec%0d in_ready after", i), bus.in_ready, 1);
      check($sformatf("vec%0d out_valid after", i), bus.out_valid, 0);
    end

    // Backpressure: 42/6 with out_ready held low for 5 cycles
    bus.dividend  = 6'd42;
    bus.divisor   = 3'd6;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    check("bp latency", lat, 7);
    q_hold = bus.quotient;
    r_hold = bus.remainder;
    check("bp quotient", q_hold, 7);
    check("bp remainder", r_hold, 0);
    for (int c = 0; c < 5; c++) begin
      if (c == 2) begin
        bus.dividend = 6'd63;
        bus.divisor  = 3'd1;
        bus.in_valid = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
      @(posedge clk); #1;
      check($sformatf("bp hold%0d out_valid", c), bus.out_valid, 1);
      check($sformatf("bp hold%0d quotient", c), bus.quotient, 7);
      check($sformatf("bp hold%0d remainder", c), bus.remainder, 0);
      check($sformatf("bp hold%0d in_ready", c), bus.in_ready, 0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp release out_valid", bus.out_valid, 0);
    check("bp release in_ready", bus.in_ready, 1);
    repeat (10) @(posedge clk);
    #1;
    check("bp ignored pulse out_valid", bus.out_valid, 0);
    check("bp ignored pulse state", state_o, IDLE);

    // Reset during the third BUSY iteration
    bus.dividend = 6'd63;
    bus.divisor  = 3'd2;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("mid state busy", state_o, BUSY);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("mid rst state", state_o, IDLE);
    check("mid rst in_ready", bus.in_ready, 1);
    check("mid rst out_valid", bus.out_valid, 0);
    check("mid rst quotient", bus.quotient, 0);
    check("mid rst remainder", bus.remainder, 0);
    check("mid rst div_by_zero", bus.div_by_zero, 0);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      check($sformatf("mid rst no result %0d", c), bus.out_valid, 0);
    end
    push_exp(6'd7, 3'd0, 1'b0);
    run_op(6'd49, 3'd7, "post rst 49/7", lat);
    check("post rst latency", lat, 7);

    // Round trip: A*B / B == A, remainder 0
    for (int a = 0; a < 8; a++) begin
      for (int b = 1; b < 8; b++) begin
        push_exp(6'(a), 3'd0, 1'b0);
        run_op(6'(a * b), 3'(b), $sformatf("rt %0d*%0d", a, b), lat);
      end
    end

    // All dividend/divisor pairs against / and %
    for (int d = 0; d < 64; d++) begin
      for (int v = 0; v < 8; v++) begin
        if (v == 0) push_exp(6'd63, 3'd0, 1'b1);
        else        push_exp(6'(d / v), 3'(d % v), 1'b0);
        run_op(6'(d), 3'(v), $sformatf("all %0d/%0d", d, v), lat);
      end
    end

    check("scoreboard drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
